// File: rtl/spi_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_bus_pkg
//  Description : Shared constants, FSM state encoding and the CRC-8 helper
//                for the SPI-to-register-bus responder.
//  Contents    : FRAME_BITS, CRC_W, CRC_INIT_DEF, frame bit positions,
//                spi_state_e, crc8()
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_bus_pkg;

    localparam int FRAME_BITS = 40;
    localparam int CRC_W = 8;
    localparam logic [CRC_W-1:0] CRC_INIT_DEF = 8'h9C;

    // Index of the last header bit (rw + address) and last crc-field bit.
    localparam int HDR_LAST_BIT = 15;
    localparam int CRC_LAST_BIT = 23;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR       = 3'd1,
        ST_RD_REQ    = 3'd2,
        ST_RD_WAIT   = 3'd3,
        ST_TX        = 3'd4,
        ST_WR_COMMIT = 3'd5
    } spi_state_e;

    // CRC-8, polynomial x^8 + x^2 + x + 1, data consumed MSB first.
    // The loop unrolls into a single combinational step.
    function automatic logic [CRC_W-1:0] crc8(
        input logic [CRC_W-1:0] init,
        input logic [15:0]      data
    );
        logic [CRC_W-1:0] crc;
        logic             fb;
        crc = init;
        for (int i = 15; i >= 0; i--) begin
            fb  = crc[CRC_W-1] ^ data[i];
            crc = {crc[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & 8'h07);
        end
        return crc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bus_responder_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_edge_sync
//  Description : Two-flop synchronisers for the host SPI clock and MOSI, plus
//                single-cycle rise/fall pulses of the synchronised SPI clock.
//  Ports       : clk, rst_n        - system clock, async active-low reset
//                spi_clk, spi_mosi - raw asynchronous host signals
//                sclk_rise/fall    - one-cycle edge pulses
//                mosi_sync         - MOSI aligned with the edge pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_sync
);

    logic [1:0] sclk_meta;
    logic       sclk_prev;
    logic [1:0] mosi_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta <= 2'b00;
            sclk_prev <= 1'b0;
            mosi_meta <= 2'b00;
        end else begin
            sclk_meta <= {sclk_meta[0], spi_clk};
            sclk_prev <= sclk_meta[1];
            mosi_meta <= {mosi_meta[0], spi_mosi};
        end
    end

    // MOSI goes through the same two-flop depth, so mosi_sync is the value
    // that was present when the rise was captured.
    assign sclk_rise = sclk_meta[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_meta[1] & sclk_prev;
    assign mosi_sync = mosi_meta[1];

endmodule
`default_nettype wire

// File: rtl/spi_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_bus_responder
//  Description : SPI target terminating a 40-bit host frame
//                {rw, addr[14:0], crc[7:0], data[15:0]} (MSB first) and
//                turning it into one internal register-bus transaction.
//                Writes issue a single-cycle bus_wr_o; reads issue bus_rd_o
//                right after the header and return {rdata, crc8} on MISO.
//  Ports       : clk_i, reset_i (async, active low)
//                spi_clk_i, spi_mosi_i, spi_miso_o - host SPI
//                bus_addr_o, bus_wdata_o, bus_wr_o, bus_rd_o,
//                bus_rdata_i, bus_rd_valid_i       - register bus
//                frame_err_o - pulse on aborted frame / read timeout
//  Options     : SPI_WR_CRC_CHECK_EN - check the crc field of write frames
//                and drop the write on mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_bus_responder
    import spi_bus_pkg::*;
#(
    parameter int              ADDR_W       = 15,
    parameter int              DATA_W       = 16,
    parameter logic [CRC_W-1:0] CRC_INIT    = CRC_INIT_DEF,
    parameter int              IDLE_TIMEOUT = 256,
    parameter int              RD_TIMEOUT   = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              spi_clk_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic              bus_wr_o,
    output logic              bus_rd_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_rd_valid_i,
    output logic              frame_err_o
);

    localparam int TX_W       = DATA_W + CRC_W;
    localparam int IDLE_CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int RD_CNT_W   = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    localparam logic [5:0] BIT_HDR_LAST   = 6'(HDR_LAST_BIT);
    localparam logic [5:0] BIT_CRC_LAST   = 6'(CRC_LAST_BIT);
    localparam logic [5:0] BIT_FRAME_LAST = 6'(FRAME_BITS - 1);
    // bit_cnt value once the rise of the first response bit has been seen;
    // falls from here on advance the response.
    localparam logic [5:0] BIT_TX_SHIFT   = 6'(HDR_LAST_BIT + 2);

    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [RD_CNT_W-1:0]   RD_LAST   = RD_CNT_W'(RD_TIMEOUT - 1);

    logic sclk_rise;
    logic sclk_fall;
    logic mosi;

    spi_edge_sync u_edge_sync (
        .clk       (clk_i),
        .rst_n     (reset_i),
        .spi_clk   (spi_clk_i),
        .spi_mosi  (spi_mosi_i),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi_sync (mosi)
    );

    spi_state_e              state;
    spi_state_e              next_state;
    logic [5:0]              bit_cnt;
    // Holds the previous DATA_W-1 bits; with the live MOSI bit it forms the
    // header at bit 15, the crc field at bit 23 and the data at bit 39.
    logic [DATA_W-2:0]       shift_reg;
    logic [TX_W-1:0]         tx_reg;
    logic [IDLE_CNT_W-1:0]   idle_cnt;
    logic [RD_CNT_W-1:0]     rd_cnt;

    logic                    idle_expired;
    logic                    frame_done;
    logic                    err_set;
    logic                    tx_load;
    logic [TX_W-1:0]         tx_load_val;

`ifdef SPI_WR_CRC_CHECK_EN
    logic [CRC_W-1:0]        crc_rx;
`endif

    assign idle_expired = (state != ST_IDLE) && !sclk_rise && (idle_cnt == IDLE_LAST);
    assign frame_done   = sclk_rise && (bit_cnt == BIT_FRAME_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        next_state  = state;
        err_set     = 1'b0;
        tx_load     = 1'b0;
        tx_load_val = '0;
        bus_rd_o    = 1'b0;
        bus_wr_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sclk_rise) begin
                    next_state = ST_HDR;
                end
            end
            ST_HDR: begin
                if (idle_expired) begin
                    next_state = ST_IDLE;
                    err_set    = 1'b1;
                end else if (sclk_rise && bit_cnt == BIT_HDR_LAST) begin
                    // shift_reg MSB holds the rw bit at this point.
                    next_state = shift_reg[DATA_W-2] ? ST_HDR : ST_RD_REQ;
                end else if (frame_done) begin
                    next_state = ST_WR_COMMIT;
                end
            end
            ST_RD_REQ: begin
                bus_rd_o   = 1'b1;
                next_state = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (idle_expired) begin
                    next_state = ST_IDLE;
                    err_set    = 1'b1;
                end else if (frame_done) begin
                    next_state = ST_IDLE;
                end else if (bus_rd_valid_i) begin
                    tx_load     = 1'b1;
                    tx_load_val = {bus_rdata_i, crc8(CRC_INIT, bus_rdata_i)};
                    next_state  = ST_TX;
                end else if (rd_cnt == RD_LAST) begin
                    // No data: answer with zeros so the host still gets a
                    // well-formed frame, and flag the failure.
                    tx_load    = 1'b1;
                    err_set    = 1'b1;
                    next_state = ST_TX;
                end
            end
            ST_TX: begin
                if (idle_expired) begin
                    next_state = ST_IDLE;
                    err_set    = 1'b1;
                end else if (frame_done) begin
                    next_state = ST_IDLE;
                end
            end
            ST_WR_COMMIT: begin
                next_state = ST_IDLE;
`ifdef SPI_WR_CRC_CHECK_EN
                if (crc_rx == crc8(CRC_INIT, bus_wdata_o)) begin
                    bus_wr_o = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
`else
                bus_wr_o = 1'b1;
`endif
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shifting, counters, bus fields, response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            tx_reg      <= '0;
            idle_cnt    <= '0;
            rd_cnt      <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= err_set;

            if (sclk_rise) begin
                shift_reg <= {shift_reg[DATA_W-3:0], mosi};
            end

            if (next_state == ST_IDLE) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt + 6'd1;
            end

            if (state == ST_IDLE || sclk_rise) begin
                idle_cnt <= '0;
            end else if (!idle_expired) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (state == ST_RD_WAIT) begin
                rd_cnt <= rd_cnt + 1'b1;
            end else begin
                rd_cnt <= '0;
            end

            if (state == ST_HDR && sclk_rise && bit_cnt == BIT_HDR_LAST) begin
                bus_addr_o <= {shift_reg[ADDR_W-2:0], mosi};
            end

            if (state == ST_HDR && next_state == ST_WR_COMMIT) begin
                bus_wdata_o <= {shift_reg, mosi};
            end

            if (tx_load) begin
                tx_reg <= tx_load_val;
            end else if (state == ST_TX && sclk_fall && bit_cnt >= BIT_TX_SHIFT) begin
                tx_reg <= {tx_reg[TX_W-2:0], 1'b0};
            end
        end
    end

`ifdef SPI_WR_CRC_CHECK_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            crc_rx <= '0;
        end else if (state == ST_HDR && sclk_rise && bit_cnt == BIT_CRC_LAST) begin
            crc_rx <= {shift_reg[CRC_W-2:0], mosi};
        end
    end
`endif

    assign spi_miso_o = (state == ST_TX) ? tx_reg[TX_W-1] : 1'b0;

endmodule
`default_nettype wire
